// File: rtl/demux_1_to_7_deser_pkg.sv
// Shared constants and output-buffer state encoding for the 1:7 deserializer.
package demux_1_to_7_deser_pkg;

   localparam int unsigned LANES = 7;
   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_LANE = 3'd6;

   typedef logic [0:0] ostate_t;
   localparam ostate_t EMPTY = 1'b0;
   localparam ostate_t FULL  = 1'b1;

endpackage

// File: rtl/demux_1_to_7_deser_lane_decoder_3_to_7.sv
// 3-to-7 one-hot write-enable decoder; index 7 yields no strobe.
module lane_decoder_3_to_7
   import demux_1_to_7_deser_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   input  logic             en_i,
   output logic [LANES-1:0] we_o
);

   always_comb begin
      we_o = '0;
      for (int k = 0; k < LANES; k++) begin
         we_o[k] = en_i && (idx_i == IDX_W'(k));
      end
   end

endmodule

// File: rtl/demux_1_to_7_deser.sv
// Serial-to-parallel collector: one bit per valid cycle into 7 lanes, completed
// words held in a single output buffer with valid/ready handshake.
module demux_1_to_7_deser
   import demux_1_to_7_deser_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             frame_start,
   output logic [LANES-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [IDX_W-1:0] lane,
   output logic             overrun,
   input  logic             overrun_clr
);

   logic [IDX_W-1:0] lane_q, lane_d;
   logic [LANES-1:0] shadow_q, shadow_d;
   logic [LANES-1:0] dout_q, dout_d;
   logic             overrun_q, overrun_d;
   ostate_t          state_q, state_d;

   logic [IDX_W-1:0] wr_idx_c;
   logic [LANES-1:0] we_c;
   logic [LANES-1:0] base_c;
   logic [LANES-1:0] word_c;
   logic             complete_c;

   // frame_start restarts the word at lane 0 with an empty shadow
   assign wr_idx_c = frame_start ? '0 : lane_q;
   assign base_c   = frame_start ? '0 : shadow_q;

   lane_decoder_3_to_7 u_dec (
      .idx_i (wr_idx_c),
      .en_i  (din_valid),
      .we_o  (we_c)
   );

   always_comb begin
      word_c = base_c;
      for (int k = 0; k < LANES; k++) begin
         if (we_c[k]) word_c[k] = din;
      end
   end

   assign complete_c = din_valid && (wr_idx_c == LAST_LANE);

   // collect path
   always_comb begin
      lane_d   = lane_q;
      shadow_d = shadow_q;
      if (din_valid) begin
         if (complete_c) begin
            lane_d   = '0;
            shadow_d = '0;
         end else begin
            lane_d   = wr_idx_c + 3'd1;
            shadow_d = word_c;
         end
      end
   end

   // output buffer FSM
   always_comb begin
      state_d   = state_q;
      dout_d    = dout_q;
      overrun_d = overrun_q && !overrun_clr;
      case (state_q)
         EMPTY: begin
            if (complete_c) begin
               dout_d  = word_c;
               state_d = FULL;
            end
         end
         FULL: begin
            if (complete_c) begin
               if (dout_ready) dout_d = word_c;
               else            overrun_d = 1'b1;
            end else if (dout_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q    <= '0;
         shadow_q  <= '0;
         dout_q    <= '0;
         overrun_q <= 1'b0;
         state_q   <= EMPTY;
      end else begin
         lane_q    <= lane_d;
         shadow_q  <= shadow_d;
         dout_q    <= dout_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = (state_q == FULL);
   assign lane       = lane_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_demux_1_to_7_deser.sv
// Directed and random bench for demux_1_to_7_deser against a bit-list reference model.
module tb_demux_1_to_7_deser;

   logic       clk = 1'b0;
   logic       rst, din, din_valid, frame_start, dout_ready, overrun_clr;
   logic [6:0] dout;
   logic       dout_valid, overrun;
   logic [2:0] lane;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit        m_bits[$];
   bit [6:0]  m_dout;
   bit        m_valid;
   bit        m_ovr;

   always #5 clk = ~clk;

   demux_1_to_7_deser dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .lane        (lane),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit d, input bit v, input bit fs,
                             input bit rdy, input bit clr);
      bit       done;
      int       w;
      done = 0;
      w    = 0;
      if (r) begin
         m_bits.delete();
         m_dout  = '0;
         m_valid = 0;
         m_ovr   = 0;
         return;
      end
      if (v) begin
         if (fs) m_bits.delete();
         m_bits.push_back(d);
         if (m_bits.size() == 7) begin
            for (int k = 0; k < 7; k++) w += int'(m_bits[k]) * (1 << k);
            m_bits.delete();
            done = 1;
         end
      end
      if (clr) m_ovr = 0;
      if (done) begin
         if (!m_valid || rdy) begin
            m_dout  = 7'(w);
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic cycle(input bit r, input bit d, input bit v, input bit fs,
                        input bit rdy, input bit clr);
      rst = r; din = d; din_valid = v; frame_start = fs;
      dout_ready = rdy; overrun_clr = clr;
      @(posedge clk);
      model_edge(r, d, v, fs, rdy, clr);
      #1;
      chk("dout", dout, m_dout);
      chk("dout_valid", 7'(dout_valid), 7'(m_valid));
      chk("overrun", 7'(overrun), 7'(m_ovr));
      chk("lane", 7'(lane), 7'(m_bits.size()));
   endtask

   // send a word lane 0 first; gap idle cycles before each bit
   task automatic send_word(input bit [6:0] w, input bit rdy_body, input bit rdy_last,
                            input int gap);
      for (int k = 0; k < 7; k++) begin
         for (int g = 0; g < gap; g++) cycle(0, 0, 0, 0, rdy_body, 0);
         cycle(0, w[k], 1, 0, (k == 6) ? rdy_last : rdy_body, 0);
      end
   endtask

   initial begin
      bit [6:0] p4;
      // test 1: reset then single word with ready high
      cycle(1, 0, 0, 0, 0, 0);
      chk("rst_dout", dout, 7'h00);
      chk("rst_lane", 7'(lane), 7'd0);
      send_word(7'h4D, 1, 1, 0);
      chk("t1_dout", dout, 7'h4D);
      chk("t1_valid", 7'(dout_valid), 7'd1);
      chk("t1_lane", 7'(lane), 7'd0);
      cycle(0, 0, 0, 0, 1, 0);
      chk("t1_valid_drop", 7'(dout_valid), 7'd0);

      // test 2: back-to-back with no ready -> overrun, then clear
      send_word(7'h4D, 0, 0, 0);
      send_word(7'h32, 0, 0, 0);
      chk("t2_dout", dout, 7'h4D);
      chk("t2_ovr", 7'(overrun), 7'd1);
      cycle(0, 0, 0, 0, 0, 1);
      chk("t2_ovr_clr", 7'(overrun), 7'd0);
      cycle(0, 0, 0, 0, 1, 0);

      // test 3: gapped valid
      send_word(7'h4D, 1, 1, 2);
      chk("t3_dout", dout, 7'h4D);
      cycle(0, 0, 0, 0, 1, 0);

      // test 4: partial word discarded by frame_start
      p4 = 7'h0F;
      for (int k = 0; k < 4; k++) cycle(0, p4[k], 1, 0, 1, 0);
      cycle(0, 1, 1, 1, 1, 0);
      chk("t4_lane", 7'(lane), 7'd1);
      for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0, 1, 0);
      cycle(0, 1, 1, 0, 1, 0);
      chk("t4_dout", dout, 7'h41);
      cycle(0, 0, 0, 0, 1, 0);

      // test 5: ready on completion cycle while FULL
      send_word(7'h4D, 0, 0, 0);
      send_word(7'h32, 0, 1, 0);
      chk("t5_dout", dout, 7'h32);
      chk("t5_valid", 7'(dout_valid), 7'd1);
      chk("t5_ovr", 7'(overrun), 7'd0);
      cycle(0, 0, 0, 0, 1, 0);

      // test 6: reset mid-word, then 7F; also drop-and-clear same cycle
      for (int k = 0; k < 3; k++) cycle(0, 1, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("t6_lane", 7'(lane), 7'd0);
      chk("t6_dout", dout, 7'h00);
      send_word(7'h7F, 1, 1, 0);
      chk("t6_dout2", dout, 7'h7F);
      for (int k = 0; k < 6; k++) cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 1);
      chk("t6_set_wins", 7'(overrun), 7'd1);

      // random phase
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 99) < 2), 1'($urandom), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) == 0), 1'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
